// File: rtl/exp_stream_sequencer.sv
// exp_stream_sequencer
// Drives one stochastic exponential evaluation on the bitstream exp unit.
// A binary operand becomes the x stream, four LFSR comparators produce the
// 1/2, 1/3, 1/4 and 1/5 coefficient streams, and y ones are counted over a
// 2**WIDTH cycle window after the unit's history has been flushed.
//
// Optional build macro: EXP_SEQ_COEFF_OVERRIDE_EN
//   Adds coeff_wr/coeff_sel/coeff_data so T2..T5 become IDLE-writable
//   registers. Without it the thresholds are fixed at floor(2**WIDTH/k).
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; x stream held at 0
// WARM   | x stream driven for WARMUP cycles to flush unit history
// RUN    | 2**WIDTH cycle window, ones-counter accumulates exp_y
// DONE   | single cycle: done high, result just loaded

module exp_stream_sequencer #(
  parameter int WIDTH  = 8,
  parameter int WARMUP = 5
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] x_value,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result,
  output logic             exp_x,
  output logic             exp_a2,
  output logic             exp_a3,
  output logic             exp_a4,
  output logic             exp_a5,
  input  logic             exp_y
`ifdef EXP_SEQ_COEFF_OVERRIDE_EN
  ,
  input  logic             coeff_wr,
  input  logic [1:0]       coeff_sel,
  input  logic [WIDTH-1:0] coeff_data
`endif
);

  localparam int FULL  = 1 << WIDTH;
  // Counter must hold both the window reload and the warm-up reload.
  localparam int CNT_W = (WIDTH > $clog2(WARMUP)) ? WIDTH : $clog2(WARMUP);

  localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] RUN_LOAD  = CNT_W'(FULL - 1);

  localparam logic [WIDTH-1:0] T2_RST = WIDTH'(FULL / 2);
  localparam logic [WIDTH-1:0] T3_RST = WIDTH'(FULL / 3);
  localparam logic [WIDTH-1:0] T4_RST = WIDTH'(FULL / 4);
  localparam logic [WIDTH-1:0] T5_RST = WIDTH'(FULL / 5);

  localparam logic [15:0] SEED_X = 16'hACE1;
  localparam logic [15:0] SEED_2 = 16'h1D87;
  localparam logic [15:0] SEED_3 = 16'h5B3C;
  localparam logic [15:0] SEED_4 = 16'hE2A9;
  localparam logic [15:0] SEED_5 = 16'h7F10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WARM = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [15:0]      lfsr_x;
  logic [15:0]      lfsr_2;
  logic [15:0]      lfsr_3;
  logic [15:0]      lfsr_4;
  logic [15:0]      lfsr_5;

  logic [WIDTH-1:0] t2;
  logic [WIDTH-1:0] t3;
  logic [WIDTH-1:0] t4;
  logic [WIDTH-1:0] t5;

  logic [WIDTH-1:0] x_lat;
  logic [WIDTH-1:0] x_cmp;
  logic [CNT_W-1:0] cycle_cnt;
  logic [WIDTH:0]   ones_cnt;
  logic [WIDTH:0]   ones_inc;
  logic             cnt_tc;
  logic             active_nxt;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form, shifting towards the MSB
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  assign cnt_tc   = (cycle_cnt == '0);
  assign ones_inc = ones_cnt + {{WIDTH{1'b0}}, exp_y};
  // On the start cycle x_lat is not loaded yet, so compare against the input.
  assign x_cmp    = (state == S_IDLE) ? x_value : x_lat;

`ifdef EXP_SEQ_COEFF_OVERRIDE_EN
  // Threshold registers, writable only while idle so a run sees fixed values
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      t2 <= T2_RST;
      t3 <= T3_RST;
      t4 <= T4_RST;
      t5 <= T5_RST;
    end else if (coeff_wr && (state == S_IDLE)) begin
      case (coeff_sel)
        2'd0:    t2 <= coeff_data;
        2'd1:    t3 <= coeff_data;
        2'd2:    t4 <= coeff_data;
        default: t5 <= coeff_data;
      endcase
    end
  end
`else
  assign t2 = T2_RST;
  assign t3 = T3_RST;
  assign t4 = T4_RST;
  assign t5 = T5_RST;
`endif

  // Random sources free-run in every state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lfsr_x <= SEED_X;
      lfsr_2 <= SEED_2;
      lfsr_3 <= SEED_3;
      lfsr_4 <= SEED_4;
      lfsr_5 <= SEED_5;
    end else begin
      lfsr_x <= lfsr_step(lfsr_x);
      lfsr_2 <= lfsr_step(lfsr_2);
      lfsr_3 <= lfsr_step(lfsr_3);
      lfsr_4 <= lfsr_step(lfsr_4);
      lfsr_5 <= lfsr_step(lfsr_5);
    end
  end

  // Registered coefficient streams, independent of the FSM
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      exp_a2 <= 1'b0;
      exp_a3 <= 1'b0;
      exp_a4 <= 1'b0;
      exp_a5 <= 1'b0;
    end else begin
      exp_a2 <= (lfsr_2[WIDTH-1:0] < t2);
      exp_a3 <= (lfsr_3[WIDTH-1:0] < t3);
      exp_a4 <= (lfsr_4[WIDTH-1:0] < t4);
      exp_a5 <= (lfsr_5[WIDTH-1:0] < t5);
    end
  end

  // x stream gated by the next state so it is 0 in exactly IDLE and DONE
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      exp_x <= 1'b0;
    end else begin
      exp_x <= active_nxt & (lfsr_x[WIDTH-1:0] < x_cmp);
    end
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort outranks the terminal count in WARM and RUN
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_WARM;
      S_WARM: begin
        if (abort)       state_nxt = S_IDLE;
        else if (cnt_tc) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (abort)       state_nxt = S_IDLE;
        else if (cnt_tc) state_nxt = S_DONE;
      end
      default:           state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    busy       = (state == S_WARM) || (state == S_RUN);
    done       = (state == S_DONE);
    active_nxt = (state_nxt == S_WARM) || (state_nxt == S_RUN);
  end

  // Operand latch, down-counter, ones-counter and result register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x_lat     <= '0;
      cycle_cnt <= '0;
      ones_cnt  <= '0;
      result    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x_lat     <= x_value;
            cycle_cnt <= WARM_LOAD;
            ones_cnt  <= '0;
          end
        end
        S_WARM: begin
          if (!abort) begin
            cycle_cnt <= cnt_tc ? RUN_LOAD : (cycle_cnt - CNT_W'(1));
          end
        end
        S_RUN: begin
          if (!abort) begin
            ones_cnt <= ones_inc;
            // Loading on the final RUN edge makes result valid during DONE.
            if (cnt_tc) result    <= ones_inc;
            else        cycle_cnt <= cycle_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_stream_sequencer.sv
// Testbench for exp_stream_sequencer (WIDTH=8, WARMUP=5).
// exp_y is produced by the bench: fixed patterns, functions of exp_x, or a
// behavioural Maclaurin-chain exp unit with a 5-deep x history.

module tb_exp_stream_sequencer;

  localparam int WIDTH  = 8;
  localparam int WARMUP = 5;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] x_value;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   result;
  logic             exp_x;
  logic             exp_a2;
  logic             exp_a3;
  logic             exp_a4;
  logic             exp_a5;
  logic             exp_y;
`ifdef EXP_SEQ_COEFF_OVERRIDE_EN
  logic             coeff_wr;
  logic [1:0]       coeff_sel;
  logic [WIDTH-1:0] coeff_data;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int last_res = 0;

  logic [3:0] xh;

  always #5 clk = ~clk;

  exp_stream_sequencer #(.WIDTH(WIDTH), .WARMUP(WARMUP)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .start(start),
    .abort(abort),
    .x_value(x_value),
    .busy(busy),
    .done(done),
    .result(result),
    .exp_x(exp_x),
    .exp_a2(exp_a2),
    .exp_a3(exp_a3),
    .exp_a4(exp_a4),
    .exp_a5(exp_a5),
    .exp_y(exp_y)
`ifdef EXP_SEQ_COEFF_OVERRIDE_EN
    ,
    .coeff_wr(coeff_wr),
    .coeff_sel(coeff_sel),
    .coeff_data(coeff_data)
`endif
  );

  // History of past x bits for the behavioural exp unit
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) xh <= 4'b0;
    else        xh <= {xh[2:0], exp_x};
  end

  typedef struct {
    logic [7:0] x;
    logic [7:0] x_late;
    int         mode;
    int         lo;
    int         hi;
    bit         xz;
    bit         abd;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // 0: y=1  1: y=0  2: y=x  3: y=~x  4: y=1 on even periods  5: exp unit
  function automatic logic y_of(input int mode, input int i);
    case (mode)
      0: return 1'b1;
      1: return 1'b0;
      2: return exp_x;
      3: return ~exp_x;
      4: return (i % 2 == 0);
      default: return ~(exp_x & ~(xh[0] & exp_a2 & ~(xh[1] & exp_a3 &
                        ~(xh[2] & exp_a4 & ~(xh[3] & exp_a5)))));
    endcase
  endfunction

  // One full evaluation. Period 1 follows the start edge; WARM 1..5,
  // RUN 6..261, DONE 262. The bench counts y itself over periods 6..261.
  task automatic run_eval(input vec_t v);
    int done_at;
    int cnt;
    int xones;
    int busy_bad;
    done_at  = -1;
    cnt      = 0;
    xones    = 0;
    busy_bad = 0;
    x_value  = v.x;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    x_value  = v.x_late;
    check("busy_rise", int'(busy), 1);
    for (int i = 1; i <= 300; i++) begin
      if (v.abd && i == 262) abort = 1'b1;
      exp_y = y_of(v.mode, i);
      if (i >= 6 && i <= 261 && exp_y) cnt++;
      if (exp_x) xones++;
      if (done) begin
        done_at = i;
        break;
      end
      if (!busy) busy_bad++;
      tick();
    end
    check("done_latency", done_at, 262);
    check("busy_during_run", busy_bad, 0);
    check("busy_in_done", int'(busy), 0);
    check("x_in_done", int'(exp_x), 0);
    check("result_exact", int'(result), cnt);
    check_range("result_range", int'(result), v.lo, v.hi);
    if (v.xz) check("x_zero_stream", xones, 0);
    tick();
    abort = 1'b0;
    check("done_one_cycle", int'(done), 0);
    check("x_after_done", int'(exp_x), 0);
    last_res = cnt;
  endtask

  initial begin
    int n;
    int c2, c3, c4, c5;

    vecs[0] = '{8'd0,   8'd0,   3, 256, 256, 1'b1, 1'b0};
    vecs[1] = '{8'd0,   8'd0,   0, 256, 256, 1'b1, 1'b0};
    vecs[2] = '{8'd0,   8'd0,   1,   0,   0, 1'b1, 1'b0};
    vecs[3] = '{8'd0,   8'd0,   4, 128, 128, 1'b1, 1'b0};
    vecs[4] = '{8'd255, 8'd255, 5,  74, 114, 1'b0, 1'b0};
    vecs[5] = '{8'd128, 8'd128, 5, 135, 175, 1'b0, 1'b0};
    vecs[6] = '{8'd255, 8'd255, 2, 226, 256, 1'b0, 1'b0};
    vecs[7] = '{8'd0,   8'd255, 3, 256, 256, 1'b1, 1'b0};
    vecs[8] = '{8'd64,  8'd64,  2,  34,  94, 1'b0, 1'b1};

    n_rst   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    x_value = '0;
    exp_y   = 1'b0;
`ifdef EXP_SEQ_COEFF_OVERRIDE_EN
    coeff_wr   = 1'b0;
    coeff_sel  = 2'd0;
    coeff_data = '0;
`endif

    // Reset state
    repeat (3) tick();
    check("rst_busy",   int'(busy),   0);
    check("rst_done",   int'(done),   0);
    check("rst_result", int'(result), 0);
    check("rst_exp_x",  int'(exp_x),  0);
    n_rst = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (busy || done || exp_x) n++;
    end
    check("idle_quiet", n, 0);

    // Table-driven evaluations
    for (int k = 0; k < 9; k++) run_eval(vecs[k]);

    // Start pulse during RUN ignored, then abort 100 cycles into RUN
    x_value = 8'd0;
    exp_y   = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int i = 1; i <= 105; i++) begin
      start = (i == 50);
      if (done) n++;
      tick();
    end
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy_falls", int'(busy), 0);
    for (int i = 0; i < 200; i++) begin
      if (done || busy) n++;
      tick();
    end
    check("abort_quiet", n, 0);
    check("abort_result_kept", int'(result), last_res);
    run_eval(vecs[3]);

    // Abort on the final RUN cycle beats the DONE transition
    x_value = 8'd0;
    exp_y   = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 261; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_last_done", int'(done), 0);
    check("abort_last_busy", int'(busy), 0);
    check("abort_last_result", int'(result), last_res);

    // start and abort together in IDLE: start wins, abort acts next cycle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    check("start_wins", int'(busy), 1);
    tick();
    abort = 1'b0;
    check("abort_in_warm", int'(busy), 0);

    // Reset mid-run
    exp_y = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 100; i++) tick();
    n_rst = 1'b0;
    #1;
    check("midrst_busy",   int'(busy),   0);
    check("midrst_done",   int'(done),   0);
    check("midrst_result", int'(result), 0);
    check("midrst_exp_x",  int'(exp_x),  0);
    repeat (3) tick();
    n_rst = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done || busy) n++;
    end
    check("midrst_quiet", n, 0);

    // Coefficient density over one full LFSR period: every low byte value
    // occurs 256 times except 0 (255 times), so count = T*256 - 1.
    c2 = 0; c3 = 0; c4 = 0; c5 = 0;
    for (int i = 0; i < 65535; i++) begin
      tick();
      c2 += int'(exp_a2);
      c3 += int'(exp_a3);
      c4 += int'(exp_a4);
      c5 += int'(exp_a5);
    end
    check("density_a2", c2, 128 * 256 - 1);
    check("density_a3", c3,  85 * 256 - 1);
    check("density_a4", c4,  64 * 256 - 1);
    check("density_a5", c5,  51 * 256 - 1);
    check_range("density_a3_tol", c3, 21845 - 700, 21845 + 700);

`ifdef EXP_SEQ_COEFF_OVERRIDE_EN
    // Zero all thresholds in IDLE; the exp chain then reduces to y = ~x
    coeff_wr   = 1'b1;
    coeff_data = '0;
    for (int s = 0; s < 4; s++) begin
      coeff_sel = 2'(s);
      tick();
    end
    coeff_wr = 1'b0;
    repeat (2) tick();
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (exp_a2 || exp_a3 || exp_a4 || exp_a5) n++;
      tick();
    end
    check("ovr_streams_zero", n, 0);
    run_eval('{8'd0, 8'd0, 5, 256, 256, 1'b1, 1'b0});

    // A write during RUN is dropped
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 50; i++) tick();
    coeff_wr   = 1'b1;
    coeff_sel  = 2'd0;
    coeff_data = 8'd128;
    tick();
    coeff_wr = 1'b0;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (exp_a2) n++;
    end
    check("ovr_run_write_dropped", n, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
